uart_nic: RTL and testbench
===========================

Name: uart_nic

Overview:
- Network-interface end of the host byte interface; the host drives it with write/read strobes.
- Accepts host bytes into a TX FIFO and serializes them onto an 8N1 UART line.
- Buffers bytes delivered by a line receiver in an RX FIFO and returns them to the host with one-cycle registered read latency.
- Exposes occupancy, availability and overflow status for host polling and LED display.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit period (50 MHz / 115200); legal range >= 2.
- ADDR_W, 3, FIFO address width; each FIFO depth = 2^ADDR_W (default 8).

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- host_wr  in  1  push host_wr_data into TX FIFO; one push per cycle held high.
- host_wr_data  in  8  byte to transmit.
- host_rd  in  1  pop RX FIFO; one pop per cycle held high.
- host_rd_data  out  8  registered byte from last accepted pop.
- rx_avail  out  1  RX FIFO non-empty.
- rx_count  out  ADDR_W+1  RX FIFO occupancy, 0..2^ADDR_W.
- tx_full  out  1  TX FIFO full.
- tx_busy  out  1  serializer not IDLE.
- tx_serial  out  1  UART line output, idle high.
- rx_byte  in  8  byte from line receiver.
- rx_byte_valid  in  1  single-cycle strobe qualifying rx_byte.
- rx_overflow  out  1  sticky: RX byte dropped because FIFO full.
- tx_overflow  out  1  sticky: host write dropped because FIFO full.

Behaviour:
Reset (async assert, sync-safe release):
- Both FIFOs empty; host_rd_data=0, rx_count=0, rx_avail=0, tx_full=0.
- tx_busy=0, tx_serial=1, both overflow flags 0.
- FSM in IDLE, bit counter and baud counter 0.
- Reset mid-frame aborts the frame immediately; the line returns high asynchronously.

TX FIFO:
- host_wr=1 and not full -> push at edge.
- host_wr=1 and full -> byte dropped, tx_overflow set.
- Full with serializer pop in the same cycle -> write accepted; count unchanged.

TX FSM (IDLE, START, DATA, STOP):
- IDLE: tx_serial=1. If FIFO non-empty, pop into shift register and go to START at the next edge.
- START: tx_serial=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles; 3-bit index increments at each bit boundary.
- STOP: tx_serial=1 for CLKS_PER_BIT cycles. At end, if FIFO non-empty, pop and go directly to START with no idle cycle; else go to IDLE.
- Frame length = 10*CLKS_PER_BIT cycles.
- tx_busy=1 in START/DATA/STOP.
- A host write to an empty FIFO while IDLE produces the start-bit falling edge 2 cycles after the write edge: push edge, then pop/transition edge.

RX FIFO:
- rx_byte_valid=1 and not full -> push.
- rx_byte_valid=1 and full -> drop, rx_overflow set, unless host_rd pops in the same cycle; then push accepted and count unchanged.
- host_rd=1 and non-empty -> host_rd_data loaded with head byte at the same edge that samples host_rd; stable until the next accepted pop.
- host_rd=1 when empty -> ignored, host_rd_data holds.
- Simultaneous push and pop on an empty FIFO -> pop ignored, push accepted.
- rx_count and rx_avail are registered, so both reflect the edge's push/pop the following cycle.

Pointers:
- ADDR_W-bit pointers wrap modulo depth.
- Occupancy counter is ADDR_W+1 bits and never exceeds 2^ADDR_W.

Overflow flags:
- Cleared only by reset.

Test Plan:
- Reset, CLKS_PER_BIT=4, host_wr 0xA5 one cycle -> tx_serial low 2 cycles after write edge; bits 1,0,1,0,0,1,0,1 each 4 cycles; stop high 4 cycles; tx_busy=0 after 40 cycles.
- host_wr 0x01 then 0xFF on consecutive cycles -> two frames back-to-back, no idle gap between stop of first and start of second; 80 busy cycles total.
- host_wr held 12 cycles with data 0..11 while serializer busy -> tx_full=1, tx_overflow=1; exactly bytes 0..8 transmitted (one popped, 8 buffered), the rest dropped.
- rx_byte_valid pulses 0x11, 0x22, 0x33 -> rx_count=3, rx_avail=1; host_rd one cycle -> host_rd_data=0x11 after that edge, rx_count=2; host_rd on empty FIFO -> host_rd_data unchanged.
- Fill RX with 8 bytes, then rx_byte_valid 0x99 with host_rd same cycle -> no overflow, count 8, 0x99 at tail; next rx_byte_valid without read -> rx_overflow=1.
- Assert rst_n low mid-DATA bit -> tx_serial=1 and tx_busy=0 immediately; FIFOs empty; after release the line stays idle.

Source files
------------

// File: rtl/uart_nic.sv
// Host byte interface to an 8N1 UART line.
// TX FIFO feeds the serializer; RX FIFO buffers line-receiver bytes for the host.
module uart_nic #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_wr,
  input  logic [7:0]        host_wr_data,
  input  logic              host_rd,
  output logic [7:0]        host_rd_data,
  output logic              rx_avail,
  output logic [ADDR_W:0]   rx_count,
  output logic              tx_full,
  output logic              tx_busy,
  output logic              tx_serial,
  input  logic [7:0]        rx_byte,
  input  logic              rx_byte_valid,
  output logic              rx_overflow,
  output logic              tx_overflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_END = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state;
  logic [BW-1:0]   baud;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            baud_end;

  logic [7:0]        tx_mem [DEPTH];
  logic [ADDR_W-1:0] tx_wp;
  logic [ADDR_W-1:0] tx_rp;
  logic [ADDR_W:0]   tx_cnt;
  logic              tx_empty;
  logic              tx_push;
  logic              tx_pop;

  logic [7:0]        rx_mem [DEPTH];
  logic [ADDR_W-1:0] rx_wp;
  logic [ADDR_W-1:0] rx_rp;
  logic              rx_full;
  logic              rx_push;
  logic              rx_pop;
  logic [ADDR_W:0]   rx_cnt_nxt;

  assign baud_end = (baud == BAUD_END);
  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == CNT_FULL);
  assign tx_busy  = (state != IDLE);

  // Serializer pulls a byte when idle or right at the end of a stop bit,
  // so queued frames go out back-to-back.
  assign tx_pop  = !tx_empty &&
                   ((state == IDLE) || ((state == STOP) && baud_end));
  assign tx_push = host_wr && (!tx_full || tx_pop);

  assign rx_full    = (rx_count == CNT_FULL);
  assign rx_pop     = host_rd && (rx_count != '0);
  assign rx_push    = rx_byte_valid && (!rx_full || rx_pop);
  assign rx_cnt_nxt = rx_count
                    + (ADDR_W+1)'(rx_push)
                    - (ADDR_W+1)'(rx_pop);

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (tx_push)
      tx_mem[tx_wp] <= host_wr_data;
  end

  // TX FIFO pointers, occupancy and sticky write-drop flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp       <= '0;
      tx_rp       <= '0;
      tx_cnt      <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (tx_push)
        tx_wp <= tx_wp + 1'b1;
      if (tx_pop)
        tx_rp <= tx_rp + 1'b1;
      tx_cnt <= tx_cnt
              + (ADDR_W+1)'(tx_push)
              - (ADDR_W+1)'(tx_pop);
      if (host_wr && tx_full && !tx_pop)
        tx_overflow <= 1'b1;
    end
  end

  // 8N1 serializer; the line is a register so reset forces it high at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud      <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      tx_serial <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          baud      <= '0;
          tx_serial <= 1'b1;
          if (!tx_empty) begin
            shreg     <= tx_mem[tx_rp];
            tx_serial <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud      <= '0;
            bit_idx   <= '0;
            tx_serial <= shreg[0];
            state     <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx_serial <= 1'b1;
              state     <= STOP;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              tx_serial <= shreg[bit_idx + 3'd1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud <= '0;
            if (!tx_empty) begin
              shreg     <= tx_mem[tx_rp];
              tx_serial <= 1'b0;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          tx_serial <= 1'b1;
        end
      endcase
    end
  end

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (rx_push)
      rx_mem[rx_wp] <= rx_byte;
  end

  // RX FIFO pointers, registered status and host read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp        <= '0;
      rx_rp        <= '0;
      rx_count     <= '0;
      rx_avail     <= 1'b0;
      host_rd_data <= '0;
      rx_overflow  <= 1'b0;
    end else begin
      if (rx_push)
        rx_wp <= rx_wp + 1'b1;
      if (rx_pop) begin
        rx_rp        <= rx_rp + 1'b1;
        host_rd_data <= rx_mem[rx_rp];
      end
      rx_count <= rx_cnt_nxt;
      rx_avail <= (rx_cnt_nxt != '0);
      if (rx_byte_valid && rx_full && !rx_pop)
        rx_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_nic.sv
// Directed bench for uart_nic with CLKS_PER_BIT=4.
// RX FIFO via a vector table; TX frames via a line decoder and cycle checks.
module tb_uart_nic;

  localparam int CPB = 4;
  localparam int AW  = 3;

  logic          clk;
  logic          rst_n;
  logic          host_wr;
  logic [7:0]    host_wr_data;
  logic          host_rd;
  logic [7:0]    host_rd_data;
  logic          rx_avail;
  logic [AW:0]   rx_count;
  logic          tx_full;
  logic          tx_busy;
  logic          tx_serial;
  logic [7:0]    rx_byte;
  logic          rx_byte_valid;
  logic          rx_overflow;
  logic          tx_overflow;

  uart_nic #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .host_wr(host_wr),
    .host_wr_data(host_wr_data),
    .host_rd(host_rd),
    .host_rd_data(host_rd_data),
    .rx_avail(rx_avail),
    .rx_count(rx_count),
    .tx_full(tx_full),
    .tx_busy(tx_busy),
    .tx_serial(tx_serial),
    .rx_byte(rx_byte),
    .rx_byte_valid(rx_byte_valid),
    .rx_overflow(rx_overflow),
    .tx_overflow(tx_overflow)
  );

  typedef struct {
    logic       rd;
    logic       v;
    logic [7:0] b;
    int         cnt;
    logic [7:0] dat;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];
  int   rxq[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Independent line decoder: samples mid-bit on the falling clock edge
  initial begin
    int mcnt;
    logic mact;
    logic [7:0] msh;
    mact = 1'b0;
    mcnt = 0;
    msh  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mact = 1'b0;
      end else if (!mact) begin
        if (tx_serial == 1'b0) begin
          mact = 1'b1;
          mcnt = 0;
        end
      end else begin
        mcnt++;
        if (mcnt >= 6 && mcnt <= 34 && (mcnt % 4) == 2)
          msh[(mcnt - 6) / 4] = tx_serial;
        if (mcnt == 38) begin
          mact = 1'b0;
          if (tx_serial) rxq.push_back(int'(msh));
          else rxq.push_back(-1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void addv(logic rd, logic v, logic [7:0] b,
                               int cnt, logic [7:0] dat, logic ovf);
    vec_t t;
    t.rd  = rd;
    t.v   = v;
    t.b   = b;
    t.cnt = cnt;
    t.dat = dat;
    t.ovf = ovf;
    vecs.push_back(t);
  endfunction

  // Called just before the pop edge; checks all 40 cycles of the frame
  task automatic frame(input logic [7:0] b, input string tag);
    logic exp;
    for (int i = 0; i < 10 * CPB; i++) begin
      tick();
      if (i == 0) host_wr = 1'b0;
      if (i < CPB) exp = 1'b0;
      else if (i >= 9 * CPB) exp = 1'b1;
      else exp = b[(i - CPB) / CPB];
      chk($sformatf("%s_line_c%0d", tag, i), 32'(tx_serial), 32'(exp));
      chk($sformatf("%s_busy_c%0d", tag, i), 32'(tx_busy), 32'd1);
    end
  endtask

  initial begin
    int n;
    int lows;
    rst_n         = 1'b0;
    host_wr       = 1'b0;
    host_wr_data  = '0;
    host_rd       = 1'b0;
    rx_byte       = '0;
    rx_byte_valid = 1'b0;
    repeat (3) tick();

    chk("rst_line", 32'(tx_serial), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_full", 32'(tx_full), 32'd0);
    chk("rst_rxcnt", 32'(rx_count), 32'd0);
    chk("rst_avail", 32'(rx_avail), 32'd0);
    chk("rst_rddata", 32'(host_rd_data), 32'd0);
    chk("rst_rxovf", 32'(rx_overflow), 32'd0);
    chk("rst_txovf", 32'(tx_overflow), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // Single frame, 2-cycle write-to-start latency
    host_wr      = 1'b1;
    host_wr_data = 8'hA5;
    tick();
    host_wr = 1'b0;
    chk("t1_pre_line", 32'(tx_serial), 32'd1);
    frame(8'hA5, "t1");
    tick();
    chk("t1_end_busy", 32'(tx_busy), 32'd0);
    chk("t1_end_line", 32'(tx_serial), 32'd1);

    // Back-to-back frames with no idle gap
    host_wr      = 1'b1;
    host_wr_data = 8'h01;
    tick();
    host_wr_data = 8'hFF;
    chk("t2_pre_line", 32'(tx_serial), 32'd1);
    frame(8'h01, "t2a");
    frame(8'hFF, "t2b");
    tick();
    chk("t2_end_busy", 32'(tx_busy), 32'd0);
    chk("t2_txovf", 32'(tx_overflow), 32'd0);

    // TX overflow: 12 held writes, bytes 0..8 survive
    rxq.delete();
    for (int k = 0; k < 12; k++) begin
      host_wr      = 1'b1;
      host_wr_data = 8'(k);
      tick();
      if (k == 7) chk("t3_full_k7", 32'(tx_full), 32'd0);
      if (k == 8) chk("t3_full_k8", 32'(tx_full), 32'd1);
      if (k == 8) chk("t3_ovf_k8", 32'(tx_overflow), 32'd0);
      if (k == 9) chk("t3_ovf_k9", 32'(tx_overflow), 32'd1);
    end
    host_wr = 1'b0;
    n = 0;
    while (tx_busy && n < 500) begin
      tick();
      n++;
    end
    chk("t3_drain_timeout", 32'(n < 500), 32'd1);
    tick();
    chk("t3_frames", 32'(rxq.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < rxq.size())
        chk($sformatf("t3_byte%0d", i), 32'(rxq[i]), 32'(i));
    end
    chk("t3_ovf_sticky", 32'(tx_overflow), 32'd1);
    chk("t3_full_end", 32'(tx_full), 32'd0);

    // RX FIFO vector table
    addv(0, 1, 8'h11, 1, 8'h00, 0);
    addv(0, 1, 8'h22, 2, 8'h00, 0);
    addv(0, 1, 8'h33, 3, 8'h00, 0);
    addv(1, 0, 8'h00, 2, 8'h11, 0);
    addv(0, 0, 8'h00, 2, 8'h11, 0);
    addv(1, 0, 8'h00, 1, 8'h22, 0);
    addv(1, 0, 8'h00, 0, 8'h33, 0);
    addv(1, 0, 8'h00, 0, 8'h33, 0);
    addv(1, 1, 8'h44, 1, 8'h33, 0);
    addv(1, 0, 8'h00, 0, 8'h44, 0);
    for (int k = 0; k < 8; k++)
      addv(0, 1, 8'h80 + 8'(k), k + 1, 8'h44, 0);
    addv(1, 1, 8'h99, 8, 8'h80, 0);
    addv(0, 1, 8'hAA, 8, 8'h80, 1);
    for (int k = 0; k < 7; k++)
      addv(1, 0, 8'h00, 7 - k, 8'h81 + 8'(k), 1);
    addv(1, 0, 8'h00, 0, 8'h99, 1);
    addv(1, 0, 8'h00, 0, 8'h99, 1);

    foreach (vecs[i]) begin
      host_rd       = vecs[i].rd;
      rx_byte_valid = vecs[i].v;
      rx_byte       = vecs[i].b;
      tick();
      chk($sformatf("rx%0d_cnt", i), 32'(rx_count), 32'(vecs[i].cnt));
      chk($sformatf("rx%0d_avail", i), 32'(rx_avail),
          32'(vecs[i].cnt != 0));
      chk($sformatf("rx%0d_data", i), 32'(host_rd_data), 32'(vecs[i].dat));
      chk($sformatf("rx%0d_ovf", i), 32'(rx_overflow), 32'(vecs[i].ovf));
    end
    host_rd       = 1'b0;
    rx_byte_valid = 1'b0;

    // Reset in the middle of a data bit
    rx_byte_valid = 1'b1;
    rx_byte       = 8'h55;
    tick();
    rx_byte       = 8'h66;
    tick();
    rx_byte_valid = 1'b0;
    chk("t6_pre_rxcnt", 32'(rx_count), 32'd2);
    host_wr      = 1'b1;
    host_wr_data = 8'h00;
    tick();
    host_wr = 1'b0;
    tick();
    repeat (6) tick();
    chk("t6_pre_line", 32'(tx_serial), 32'd0);
    chk("t6_pre_busy", 32'(tx_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_line", 32'(tx_serial), 32'd1);
    chk("t6_busy", 32'(tx_busy), 32'd0);
    chk("t6_rxcnt", 32'(rx_count), 32'd0);
    chk("t6_avail", 32'(rx_avail), 32'd0);
    chk("t6_full", 32'(tx_full), 32'd0);
    chk("t6_rxovf", 32'(rx_overflow), 32'd0);
    chk("t6_txovf", 32'(tx_overflow), 32'd0);
    chk("t6_rddata", 32'(host_rd_data), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!tx_serial || tx_busy) lows++;
    end
    chk("t6_idle_after", 32'(lows), 32'd0);
    host_rd = 1'b1;
    tick();
    host_rd = 1'b0;
    chk("t6_rd_empty", 32'(host_rd_data), 32'd0);
    chk("t6_rd_cnt", 32'(rx_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
